// File: rtl/spi_flash_reader.sv
// SPI NOR flash read controller (mode 0): random-address reads plus CS-held sequential streaming.
// Define SPI_FLASH_FAST_READ_EN to issue FAST READ (0x0B) with 8 dummy clocks instead of READ (0x03).
module spi_flash_reader #(
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned CS_HIGH_MIN    = 4,
    parameter logic [15:0] STARTUP_CYCLES = 16'd300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] flash_addr,
    input  logic        flash_req_r_addr,
    input  logic        flash_req_r_next,
    output logic        flash_d_ready,
    output logic [7:0]  flash_d_out,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [3:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_CS_HIGH,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_READY
    } state_e;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif

    localparam logic [15:0] DIV_LAST     = 16'(CLK_DIV - 1);
    localparam logic [15:0] CS_HIGH_LAST = 16'(CS_HIGH_MIN - 1);
    localparam logic [15:0] STARTUP_LAST = STARTUP_CYCLES - 16'd1;

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [23:0] addr_q, addr_d;
    logic        pending_q, pending_d;
    logic [7:0]  dout_q, dout_d;
    logic        ready_q, ready_d;
    logic        half_end;
    logic        bit_done;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        addr_d    = addr_q;
        pending_d = pending_q;
        dout_d    = dout_q;
        ready_d   = ready_q;
        half_end  = (div_q == DIV_LAST);
        bit_done  = 1'b0;

        // Shared bit engine: MISO sampled as SCLK rises, MOSI advances as SCLK falls.
        if (state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA}) begin
            if (half_end) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    if (state_q == ST_DATA) rx_d = {rx_q[6:0], spi_miso};
                end else begin
                    sclk_d   = 1'b0;
                    tx_d     = {tx_q[30:0], 1'b0};
                    bit_d    = bit_q - 6'd1;
                    bit_done = (bit_q == 6'd1);
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        case (state_q)
            ST_STARTUP: begin
                if (wait_q == '0) begin
                    if (pending_q) begin
                        state_d   = ST_CS_SETUP;
                        wait_d    = DIV_LAST;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            ST_IDLE: ;
            ST_CS_HIGH: begin
                if (wait_q == '0) begin
                    state_d = ST_CS_SETUP;
                    wait_d  = DIV_LAST;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            ST_CS_SETUP: begin
                if (wait_q == '0) begin
                    state_d = ST_CMD;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    bit_d   = 6'd8;
                    tx_d    = {READ_CMD, addr_q};
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            ST_CMD: begin
                if (bit_done) begin
                    state_d = ST_ADDR;
                    bit_d   = 6'd24;
                end
            end
            ST_ADDR: begin
                if (bit_done) begin
`ifdef SPI_FLASH_FAST_READ_EN
                    state_d = ST_DUMMY;
`else
                    state_d = ST_DATA;
`endif
                    bit_d = 6'd8;
                end
            end
            ST_DUMMY: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    bit_d   = 6'd8;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    state_d = ST_READY;
                    dout_d  = rx_q;
                    ready_d = 1'b1;
                end
            end
            ST_READY: begin
                if (flash_req_r_next) begin
                    state_d = ST_DATA;
                    bit_d   = 6'd8;
                    div_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: state_d = ST_STARTUP;
        endcase

        // A new address overrides everything else, including a simultaneous next request.
        if (flash_req_r_addr) begin
            addr_d  = flash_addr;
            ready_d = 1'b0;
            sclk_d  = 1'b0;
            tx_d    = '0;
            div_d   = '0;
            case (state_q)
                ST_STARTUP: begin
                    if (wait_q == '0) begin
                        state_d   = ST_CS_SETUP;
                        wait_d    = DIV_LAST;
                        pending_d = 1'b0;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                ST_IDLE, ST_CS_SETUP: begin
                    state_d = ST_CS_SETUP;
                    wait_d  = DIV_LAST;
                end
                default: begin
                    state_d = ST_CS_HIGH;
                    wait_d  = CS_HIGH_LAST;
                end
            endcase
        end

        cs_n_d = (state_d inside {ST_STARTUP, ST_IDLE, ST_CS_HIGH});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STARTUP;
            wait_q    <= STARTUP_LAST;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            tx_q      <= '0;
            rx_q      <= '0;
            addr_q    <= '0;
            pending_q <= 1'b0;
            dout_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
        end
    end

    assign spi_cs_n      = cs_n_q;
    assign spi_sclk      = sclk_q;
    assign spi_mosi      = tx_q[31];
    assign flash_d_ready = ready_q;
    assign flash_d_out   = dout_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: behavioural SPI flash model plus latency/sequence checks.
// Honours SPI_FLASH_FAST_READ_EN for the expected command byte and dummy clocks.
module tb_spi_flash_reader;

    localparam int CLK_DIV     = 2;
    localparam int CS_HIGH_MIN = 4;
    localparam int STARTUP     = 300;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] EXP_CMD = 8'h0B;
    localparam int DUMMY_BITS      = 8;
`else
    localparam logic [7:0] EXP_CMD = 8'h03;
    localparam int DUMMY_BITS      = 0;
`endif
    localparam int BIT_CYC   = 2 * CLK_DIV;
    localparam int LAT_IDLE  = CLK_DIV + (8 + 24 + DUMMY_BITS + 8) * BIT_CYC;
    localparam int LAT_NEXT  = 8 * BIT_CYC;
    localparam int LAT_ABORT = CS_HIGH_MIN + LAT_IDLE;

    logic        clk;
    logic        rst_n;
    logic [23:0] flash_addr;
    logic        flash_req_r_addr;
    logic        flash_req_r_next;
    logic        flash_d_ready;
    logic [7:0]  flash_d_out;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    spi_flash_reader #(
        .CLK_DIV       (CLK_DIV),
        .CS_HIGH_MIN   (CS_HIGH_MIN),
        .STARTUP_CYCLES(16'(STARTUP))
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flash_addr      (flash_addr),
        .flash_req_r_addr(flash_req_r_addr),
        .flash_req_r_next(flash_req_r_next),
        .flash_d_ready   (flash_d_ready),
        .flash_d_out     (flash_d_out),
        .spi_cs_n        (spi_cs_n),
        .spi_sclk        (spi_sclk),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso)
    );

    // ---------------- clock / global counters ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int cs_hi_run  = 0;
    int last_cs_hi = 0;
    always @(posedge clk) begin
        if (spi_cs_n === 1'b1) begin
            cs_hi_run <= cs_hi_run + 1;
        end else begin
            if (cs_hi_run != 0) last_cs_hi <= cs_hi_run;
            cs_hi_run <= 0;
        end
    end

    int sclk_rises = 0;
    int cs_rises   = 0;
    always @(posedge spi_sclk) sclk_rises++;
    always @(posedge spi_cs_n) cs_rises++;

    // ---------------- flash memory contents ----------------
    logic [7:0] mem_ovr [logic [23:0]];

    function automatic logic [7:0] model_byte(input logic [23:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[3:0], a[7:4]} ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    // ---------------- behavioural SPI NOR flash (mode 0) ----------------
    int          fl_bits = 0;
    logic [7:0]  fl_cmd  = '0;
    logic [23:0] fl_addr = '0;
    logic [7:0]  cap_cmd = '0;
    logic [23:0] cap_addr = '0;

    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n === 1'b1) begin
            fl_bits = 0;
            fl_cmd  = '0;
            fl_addr = '0;
        end else begin
            if (fl_bits < 8) fl_cmd = {fl_cmd[6:0], spi_mosi};
            else if (fl_bits < 32) fl_addr = {fl_addr[22:0], spi_mosi};
            fl_bits++;
            if (fl_bits == 32) begin
                cap_cmd  = fl_cmd;
                cap_addr = fl_addr;
            end
        end
    end

    always @(negedge spi_sclk) begin
        int start;
        int idx;
        logic [7:0] b;
        start = (fl_cmd == 8'h0B) ? 40 : 32;
        if (spi_cs_n === 1'b0 && fl_bits >= start) begin
            idx = fl_bits - start;
            b = model_byte(fl_addr + 24'(idx / 8));
            spi_miso = b[7 - (idx % 8)];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_addr(input logic [23:0] a, output int rc);
        @(negedge clk);
        flash_addr = a;
        flash_req_r_addr = 1'b1;
        @(negedge clk);
        flash_req_r_addr = 1'b0;
        rc = cyc;
    endtask

    task automatic pulse_next(output int rc);
        @(negedge clk);
        flash_req_r_next = 1'b1;
        @(negedge clk);
        flash_req_r_next = 1'b0;
        rc = cyc;
    endtask

    task automatic pulse_both(input logic [23:0] a, output int rc);
        @(negedge clk);
        flash_addr = a;
        flash_req_r_addr = 1'b1;
        flash_req_r_next = 1'b1;
        @(negedge clk);
        flash_req_r_addr = 1'b0;
        flash_req_r_next = 1'b0;
        rc = cyc;
    endtask

    // Returns cycles from request edge to flash_d_ready rising, or -1 on timeout.
    task automatic wait_lat(input int rc, input int max, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < max) begin
            @(posedge clk);
            #1;
            n++;
            if (flash_d_ready === 1'b1) begin
                lat = cyc - rc;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int base, rises0, rc, lat;
        flash_req_r_addr = 1'b0;
        flash_req_r_next = 1'b0;
        flash_addr = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0 ||
            flash_d_ready !== 1'b0 || flash_d_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: cs_n=%b sclk=%b mosi=%b ready=%b dout=%h, expected 1 0 0 0 00",
                     spi_cs_n, spi_sclk, spi_mosi, flash_d_ready, flash_d_out);
        end
        rst_n = 1'b1;
        base = cyc;
        rises0 = sclk_rises;
        while (cyc < base + 5) @(negedge clk);
        pulse_addr(24'h010000, rc);
        while (cyc < base + 100) @(negedge clk);
        checks++;
        if (spi_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL startup_cs: cs_n=%b during startup, expected 1", spi_cs_n);
        end
        while (cyc < base + STARTUP) @(negedge clk);
        checks++;
        if (sclk_rises != rises0) begin
            errors++;
            $display("FAIL startup_quiet: %0d sclk edges before cycle %0d, expected 0", sclk_rises - rises0, STARTUP);
        end
        wait_lat(rc, 1000, lat);
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL startup_ready: no flash_d_ready after pending request, expected within 1000 cycles");
        end
        checks++;
        if (cap_cmd !== EXP_CMD || cap_addr !== 24'h010000) begin
            errors++;
            $display("FAIL startup_cmd: cmd=%h addr=%h, expected %h 010000", cap_cmd, cap_addr, EXP_CMD);
        end
        checks++;
        if (flash_d_out !== 8'hA5 || spi_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL startup_data: dout=%h cs_n=%b, expected a5 0", flash_d_out, spi_cs_n);
        end
    endtask

    task automatic test_streaming();
        int rc, lat, r0, c0;
        logic [7:0] exp_b;
        for (int k = 1; k <= 4; k++) begin
            exp_b = model_byte(24'h010000 + 24'(k));
            r0 = sclk_rises;
            c0 = cs_rises;
            pulse_next(rc);
            checks++;
            if (flash_d_ready !== 1'b0) begin
                errors++;
                $display("FAIL stream_drop[%0d]: ready=%b after request, expected 0", k, flash_d_ready);
            end
            wait_lat(rc, 200, lat);
            checks++;
            if (lat != LAT_NEXT) begin
                errors++;
                $display("FAIL stream_latency[%0d]: %0d cycles, expected %0d", k, lat, LAT_NEXT);
            end
            checks++;
            if (flash_d_out !== exp_b) begin
                errors++;
                $display("FAIL stream_data[%0d]: dout=%h, expected %h", k, flash_d_out, exp_b);
            end
            checks++;
            if (sclk_rises - r0 != 8 || cs_rises != c0) begin
                errors++;
                $display("FAIL stream_bus[%0d]: %0d sclk edges, %0d cs rises, expected 8 and 0",
                         k, sclk_rises - r0, cs_rises - c0);
            end
        end
    endtask

    task automatic test_abort();
        int rc, lat;
        pulse_addr(24'h000100, rc);
        repeat (40) @(negedge clk);
        pulse_addr(24'hFFFFFF, rc);
        wait_lat(rc, 500, lat);
        checks++;
        if (lat != LAT_ABORT) begin
            errors++;
            $display("FAIL abort_latency: %0d cycles, expected %0d", lat, LAT_ABORT);
        end
        checks++;
        if (last_cs_hi < CS_HIGH_MIN) begin
            errors++;
            $display("FAIL abort_cs_high: cs high %0d cycles, expected >= %0d", last_cs_hi, CS_HIGH_MIN);
        end
        checks++;
        if (cap_cmd !== EXP_CMD || cap_addr !== 24'hFFFFFF || flash_d_out !== model_byte(24'hFFFFFF)) begin
            errors++;
            $display("FAIL abort_data: cmd=%h addr=%h dout=%h, expected %h ffffff %h",
                     cap_cmd, cap_addr, flash_d_out, EXP_CMD, model_byte(24'hFFFFFF));
        end
        pulse_next(rc);
        wait_lat(rc, 200, lat);
        checks++;
        if (lat != LAT_NEXT || flash_d_out !== model_byte(24'h000000)) begin
            errors++;
            $display("FAIL wrap_data: lat=%0d dout=%h, expected %0d %h", lat, flash_d_out, LAT_NEXT,
                     model_byte(24'h000000));
        end
    endtask

    task automatic test_ignore_next();
        int rc, rc2, lat, r0;
        logic [23:0] a;
        a = 24'h00ABCD;
        r0 = sclk_rises;
        pulse_addr(a, rc);
        repeat (12) @(negedge clk);
        pulse_next(rc2);
        wait_lat(rc, 500, lat);
        checks++;
        if (lat != LAT_ABORT || flash_d_out !== model_byte(a)) begin
            errors++;
            $display("FAIL ignore_next: lat=%0d dout=%h, expected %0d %h", lat, flash_d_out, LAT_ABORT, model_byte(a));
        end
        checks++;
        if (sclk_rises - r0 != 40 + DUMMY_BITS) begin
            errors++;
            $display("FAIL ignore_next_clocks: %0d sclk edges, expected %0d", sclk_rises - r0, 40 + DUMMY_BITS);
        end
    endtask

    task automatic test_both();
        int rc, lat;
        logic [23:0] a;
        a = 24'h5A5A00;
        pulse_both(a, rc);
        wait_lat(rc, 500, lat);
        checks++;
        if (lat != LAT_ABORT || cap_addr !== a || flash_d_out !== model_byte(a)) begin
            errors++;
            $display("FAIL addr_wins: lat=%0d addr=%h dout=%h, expected %0d %h %h",
                     lat, cap_addr, flash_d_out, LAT_ABORT, a, model_byte(a));
        end
    endtask

    task automatic test_random();
        int rc, lat, n;
        logic [23:0] a;
        logic [7:0] exp_q[$];
        logic [7:0] e;
        for (int it = 0; it < 5; it++) begin
            a = (it == 0) ? 24'hFFFFFE : 24'($urandom_range(0, 24'hFFFFFF));
            exp_q.push_back(model_byte(a));
            pulse_addr(a, rc);
            wait_lat(rc, 500, lat);
            e = exp_q.pop_front();
            checks++;
            if (lat != LAT_ABORT || cap_addr !== a || flash_d_out !== e) begin
                errors++;
                $display("FAIL rand_addr[%0d]: lat=%0d addr=%h dout=%h, expected %0d %h %h",
                         it, lat, cap_addr, flash_d_out, LAT_ABORT, a, e);
            end
            n = $urandom_range(1, 3);
            for (int k = 1; k <= n; k++) begin
                exp_q.push_back(model_byte(a + 24'(k)));
                pulse_next(rc);
                wait_lat(rc, 200, lat);
                e = exp_q.pop_front();
                checks++;
                if (lat != LAT_NEXT || flash_d_out !== e) begin
                    errors++;
                    $display("FAIL rand_next[%0d.%0d]: lat=%0d dout=%h, expected %0d %h",
                             it, k, lat, flash_d_out, LAT_NEXT, e);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int rc;
        pulse_next(rc);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (spi_sclk !== 1'b1 || spi_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_data: sclk=%b cs_n=%b, expected 1 0", spi_sclk, spi_cs_n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || flash_d_ready !== 1'b0 ||
            spi_mosi !== 1'b0 || flash_d_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: cs_n=%b sclk=%b ready=%b mosi=%b dout=%h, expected 1 0 0 0 00",
                     spi_cs_n, spi_sclk, flash_d_ready, spi_mosi, flash_d_out);
        end
        test_reset();
    endtask

    task automatic test_idle_latency();
        int base, rc, lat;
        logic [23:0] a;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        while (cyc < base + STARTUP + 10) @(negedge clk);
        a = 24'h123456;
        pulse_addr(a, rc);
        wait_lat(rc, 500, lat);
        checks++;
        if (lat != LAT_IDLE) begin
            errors++;
            $display("FAIL idle_latency: %0d cycles, expected %0d", lat, LAT_IDLE);
        end
        checks++;
        if (cap_cmd !== EXP_CMD || cap_addr !== a || flash_d_out !== model_byte(a)) begin
            errors++;
            $display("FAIL idle_data: cmd=%h addr=%h dout=%h, expected %h %h %h",
                     cap_cmd, cap_addr, flash_d_out, EXP_CMD, a, model_byte(a));
        end
    endtask

    initial begin
        mem_ovr[24'h010000] = 8'hA5;
        mem_ovr[24'h010001] = 8'h11;
        mem_ovr[24'h010002] = 8'h22;
        mem_ovr[24'h010003] = 8'h33;
        mem_ovr[24'h010004] = 8'h44;
        test_reset();
        test_streaming();
        test_abort();
        test_ignore_next();
        test_both();
        test_random();
        test_async_reset();
        test_idle_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
